// File: rtl/riscorvo_arb_pkg.sv
// rtl/riscorvo_arb_pkg.sv - shared types and constants for the riscorvo memory arbiter
//
// Purpose : FSM state encoding, requester identifiers and the default
//           memory-wait timeout used by riscorvo_mem_arbiter and its timer.
// Ports   : none (package).
package riscorvo_arb_pkg;

   localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_t;

   // Map a requester to the grant state that serves it.
   function automatic arb_state_t grant_of(input req_id_t id);
      return (id == REQ_DATA) ? ARB_GRANT_D : ARB_GRANT_I;
   endfunction

endpackage

// File: rtl/riscorvo_arb_timer.sv
// rtl/riscorvo_arb_timer.sv - memory-wait counter with timeout compare
//
// Purpose : counts cycles a granted transaction waits on memory and flags
//           when the count reaches TIMEOUT_CYCLES.
// Ports   : clk, reset_n   - clock, asynchronous active-low reset
//           clear          - return the count to zero (has priority)
//           count_en       - advance the count by one this cycle
//           expired        - count equals TIMEOUT_CYCLES
module riscorvo_arb_timer
   import riscorvo_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt;

   // Saturate at LIMIT so the compare cannot wrap if clear is late.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count_en && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/riscorvo_mem_arbiter.sv
// rtl/riscorvo_mem_arbiter.sv - two-requester arbiter onto a single memory port
//
// Purpose : shares one memory port between instruction fetch and load/store.
//           Requests are arbitrated in IDLE, the winner's signals are passed
//           straight through while granted, and a stalled transaction is
//           aborted after TIMEOUT_CYCLES wait cycles.
//           Build option RISCORVO_ARB_ROUND_ROBIN_EN: simultaneous requests
//           alternate between requesters; otherwise the data port always wins.
// Ports   : clk, reset_n                        - clock, async active-low reset
//           valid/addr_instr_i, ready/data_instr_o - fetch requester
//           valid/addr/write_data/read_write/mask_data_i,
//           ready_data_o, read_data_o          - load/store requester
//           valid/addr/write_data/read_write/mask_mem_o,
//           ready_mem_i, read_data_mem_i       - shared memory port
//           timeout_o                          - pulse on aborted transaction
module riscorvo_mem_arbiter
   import riscorvo_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_instr_i,
   input  logic [ADDR_W-1:0] addr_instr_i,
   output logic              ready_instr_o,
   output logic [31:0]       data_instr_o,
   input  logic              valid_data_i,
   input  logic [ADDR_W-1:0] addr_data_i,
   input  logic [31:0]       write_data_i,
   input  logic              read_write_i,
   input  logic [3:0]        mask_data_i,
   output logic              ready_data_o,
   output logic [31:0]       read_data_o,
   output logic              valid_mem_o,
   output logic [ADDR_W-1:0] addr_mem_o,
   output logic [31:0]       write_data_mem_o,
   output logic              read_write_mem_o,
   output logic [3:0]        mask_mem_o,
   input  logic              ready_mem_i,
   input  logic [31:0]       read_data_mem_i,
   output logic              timeout_o
);

   arb_state_t state;
   arb_state_t state_nxt;
   req_id_t    both_winner;

   logic is_gi;
   logic is_gd;
   logic gvalid;
   logic other_valid;
   logic expired;
   logic abort;
   logic done;

   assign is_gi = (state == ARB_GRANT_I);
   assign is_gd = (state == ARB_GRANT_D);

   assign gvalid      = (is_gi & valid_instr_i) | (is_gd & valid_data_i);
   assign other_valid = (is_gi & valid_data_i)  | (is_gd & valid_instr_i);

   // Abort wins over a same-cycle memory ready: valid_mem_o is already low then.
   assign abort = gvalid & expired;
   assign done  = gvalid & ready_mem_i & ~abort;

   riscorvo_arb_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (~gvalid | done | abort),
      .count_en(gvalid & ~ready_mem_i),
      .expired (expired)
   );

`ifdef RISCORVO_ARB_ROUND_ROBIN_EN
   req_id_t last_served;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_served <= REQ_INSTR;
      end else if (done || abort) begin
         last_served <= is_gd ? REQ_DATA : REQ_INSTR;
      end
   end

   assign both_winner = (last_served == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
`else
   assign both_winner = REQ_DATA;
`endif

   // A requester sees ready in the same cycle it is served, so its valid is
   // still high at the completion edge; staying granted and releasing on the
   // following cycle (valid low) is what returns an idle requester to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (valid_instr_i && valid_data_i) begin
               state_nxt = grant_of(both_winner);
            end else if (valid_data_i) begin
               state_nxt = ARB_GRANT_D;
            end else if (valid_instr_i) begin
               state_nxt = ARB_GRANT_I;
            end
         end
         ARB_GRANT_I, ARB_GRANT_D: begin
            if (!gvalid || abort) begin
               state_nxt = ARB_IDLE;
            end else if (done && other_valid) begin
               state_nxt = is_gi ? ARB_GRANT_D : ARB_GRANT_I;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Memory port mirrors the granted requester; instruction fetch is a full-word read.
   assign valid_mem_o      = gvalid & ~abort;
   assign addr_mem_o       = is_gi ? addr_instr_i : (is_gd ? addr_data_i : '0);
   assign write_data_mem_o = is_gd ? write_data_i : 32'h0;
   assign read_write_mem_o = is_gd & read_write_i;
   assign mask_mem_o       = is_gi ? 4'hF : (is_gd ? mask_data_i : 4'h0);

   assign ready_instr_o = is_gi & (done | abort);
   assign data_instr_o  = (is_gi & done) ? read_data_mem_i : 32'h0;
   assign ready_data_o  = is_gd & (done | abort);
   assign read_data_o   = (is_gd & done) ? read_data_mem_i : 32'h0;
   assign timeout_o     = abort;

endmodule

// File: doc/riscorvo_mem_arbiter.md
RISCORVO_MEM_ARBITER -- requirements
Module: riscorvo_mem_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 255, memory-wait cycles before forced abort; ADDR_W, default 32, address width.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 valid_instr_i  input  1  instruction fetch request, held until ready_instr_o.
REQ-005 addr_instr_i  input  ADDR_W  fetch address.
REQ-006 ready_instr_o  output  1  one-cycle fetch completion.
REQ-007 data_instr_o  output  32  fetched word, valid with ready_instr_o.
REQ-008 valid_data_i  input  1  load/store request, held until ready_data_o.
REQ-009 addr_data_i / write_data_i  input  ADDR_W / 32  data address / store data.
REQ-010 read_write_i  input  1  1 = write, 0 = read.
REQ-011 mask_data_i  input  4  byte enables.
REQ-012 ready_data_o / read_data_o  output  1 / 32  data completion / load data.
REQ-013 valid_mem_o, addr_mem_o, write_data_mem_o, read_write_mem_o, mask_mem_o  output  1, ADDR_W, 32, 1, 4  shared memory port request.
REQ-014 ready_mem_i / read_data_mem_i  input  1 / 32  memory completion / read data.
REQ-015 timeout_o  output  1  one-cycle pulse on aborted transaction.

Function
REQ-016 FSM states SHALL be IDLE, GRANT_I, GRANT_D; state register only, outputs decoded from state.
REQ-017 IDLE: valid_mem_o=0; any pending request moves to its GRANT state next cycle (1-cycle arbitration latency).
REQ-018 Both pending in IDLE: winner per REQ-030/031.
REQ-019 GRANT_x: memory outputs SHALL mirror granted requester's signals combinationally; valid_mem_o = that requester's valid.
REQ-020 GRANT_x: ready_mem_i SHALL pass combinationally to that requester's ready; read_data_mem_i to its data output; other requester's ready=0.
REQ-021 On completion (ready_mem_i=1) in GRANT_x: other requester pending -> switch directly to its GRANT state; else same requester still valid -> stay (back-to-back); else IDLE.
REQ-022 Grant SHALL never change mid-transaction; requester dropping valid before ready (protocol violation) returns FSM to IDLE next cycle.
REQ-023 Wait counter (width ceil(log2(TIMEOUT_CYCLES+1))) SHALL clear on grant entry and completion, increment each GRANT cycle with ready_mem_i=0.
REQ-024 Counter reaching TIMEOUT_CYCLES: assert granted ready for one cycle with read data 0, pulse timeout_o, deassert valid_mem_o that cycle, go IDLE.
REQ-025 ready_mem_i in IDLE SHALL be ignored (no ready to either requester).
REQ-026 data_instr_o/read_data_o SHALL be 0 when their ready is 0.

Reset
REQ-027 reset_n low SHALL force state IDLE, counter 0, round-robin pointer to instruction-last, immediately (asynchronous).
REQ-028 During reset: valid_mem_o, ready_instr_o, ready_data_o, timeout_o SHALL be 0; all data/address outputs 0.
REQ-029 Reset mid-transaction SHALL abandon it without ready to requester; first grant after release follows REQ-017.

Configuration
REQ-030 With RISCORVO_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not served last (1-bit pointer updated on each completion).
REQ-031 Without it: fixed priority, data port wins over instruction port.

Structure
REQ-032 Package riscorvo_arb_pkg SHALL hold the state enum (arb_state_t) and requester-id typedef; TIMEOUT default constant there.
REQ-033 Single sub-module riscorvo_arb_timer (wait counter + timeout compare) is natural; remainder flat.

Verification
REQ-034 Instr only, addr 0x100, ready_mem_i after 2 wait cycles -> valid_mem_o from cycle 1, ready_instr_o with data 0xDEADBEEF at cycle 3, back to IDLE.
REQ-035 Both valid same cycle, RR enabled, last served instr -> data granted first, then instr granted directly with no IDLE cycle.
REQ-036 Same as 035 without macro, 3 repeated rounds -> data always first; instr served only when data idle.
REQ-037 TIMEOUT_CYCLES=4, ready_mem_i never -> ready_data_o + timeout_o pulse after 4 waits, read_data_o=0, state IDLE.
REQ-038 reset_n low during GRANT_D wait -> outputs 0 same cycle, no ready_data_o, grant restarts after release.
REQ-039 Store 0x12345678 mask 0b0011 addr 0x2004 -> read_write_mem_o=1, mask_mem_o=0b0011, data/addr exact on memory port.
